ps2_keymatrix: RTL and testbench

- Downstream consumer of the PS/2 core's received-byte stream (8-bit data, valid/ready).
- Decodes Set-2 make/break sequences, including the E0 and F0 prefixes and the E1 Pause sequence.
- Maintains an 8x5 Spectrum-style key matrix.
- The CPU keyboard port reads the matrix: it drives address high byte A15..A8 as active-low row selects and gets active-low column bits back.

---
 rtl/ps2_keymatrix_pkg.sv | 52 +++++
 rtl/ps2_keymatrix_if.sv | 9 +
 rtl/ps2_keymap.sv | 78 +++++++
 rtl/ps2_keymatrix.sv | 213 +++++++++++++++++++++
 tb/tb_ps2_keymatrix.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_keymatrix_pkg.sv
// Shared types and constants for the PS/2 Set-2 to Spectrum key matrix decoder.
package ps2_keymatrix_pkg;

  localparam int unsigned ROWS_DEF = 8;
  localparam int unsigned COLS_DEF = 5;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_RESEND = 8'hFE;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_EXT     = 3'd1;
  localparam logic [2:0] ST_BRK     = 3'd2;
  localparam logic [2:0] ST_EXT_BRK = 3'd3;
  localparam logic [2:0] ST_SKIP    = 3'd4;

  typedef enum logic [2:0] {
    StIdle   = ST_IDLE,
    StExt    = ST_EXT,
    StBrk    = ST_BRK,
    StExtBrk = ST_EXT_BRK,
    StSkip   = ST_SKIP
  } fsm_state_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] row;
    logic [2:0] col;
    logic       combo;
  } key_pos_t;

  // Held-bit slot for each combo key, derived from the digit it drives.
  function automatic logic [2:0] combo_idx(input logic [2:0] row, input logic [2:0] col);
    logic [2:0] idx;
    if (row == 3'd3) begin
      idx = 3'd1;
    end else begin
      case (col)
        3'd4:    idx = 3'd2;
        3'd3:    idx = 3'd3;
        3'd2:    idx = 3'd4;
        default: idx = 3'd0;
      endcase
    end
    return idx;
  endfunction

endpackage

// File: rtl/ps2_keymatrix_if.sv
// Received-byte stream from the PS/2 core (valid/ready).
interface ps2_keymatrix_if;
  logic [7:0] scan_data;
  logic       scan_valid;
  logic       scan_ready;

  modport master (output scan_data, output scan_valid, input scan_ready);
  modport slave (input scan_data, input scan_valid, output scan_ready);
endinterface

// File: rtl/ps2_keymap.sv
// Combinational Set-2 scancode to Spectrum matrix position lookup.
module ps2_keymap
  import ps2_keymatrix_pkg::*;
(
  input  logic       ext_i,
  input  logic [7:0] code_i,
  output key_pos_t   pos_o
);

  // rc is {row, col} written as two octal digits.
  function automatic key_pos_t kp(input logic [5:0] rc, input logic combo);
    key_pos_t p;
    p.valid = 1'b1;
    p.row   = rc[5:3];
    p.col   = rc[2:0];
    p.combo = combo;
    return p;
  endfunction

  always_comb begin
    pos_o = '0;
    if (ext_i) begin
      case (code_i)
        8'h6B:   pos_o = kp(6'o34, 1'b1);
        8'h72:   pos_o = kp(6'o44, 1'b1);
        8'h75:   pos_o = kp(6'o43, 1'b1);
        8'h74:   pos_o = kp(6'o42, 1'b1);
        default: pos_o = '0;
      endcase
    end else begin
      case (code_i)
        8'h12, 8'h59: pos_o = kp(6'o00, 1'b0);
        8'h1A: pos_o = kp(6'o01, 1'b0);
        8'h22: pos_o = kp(6'o02, 1'b0);
        8'h21: pos_o = kp(6'o03, 1'b0);
        8'h2A: pos_o = kp(6'o04, 1'b0);
        8'h1C: pos_o = kp(6'o10, 1'b0);
        8'h1B: pos_o = kp(6'o11, 1'b0);
        8'h23: pos_o = kp(6'o12, 1'b0);
        8'h2B: pos_o = kp(6'o13, 1'b0);
        8'h34: pos_o = kp(6'o14, 1'b0);
        8'h15: pos_o = kp(6'o20, 1'b0);
        8'h1D: pos_o = kp(6'o21, 1'b0);
        8'h24: pos_o = kp(6'o22, 1'b0);
        8'h2D: pos_o = kp(6'o23, 1'b0);
        8'h2C: pos_o = kp(6'o24, 1'b0);
        8'h16: pos_o = kp(6'o30, 1'b0);
        8'h1E: pos_o = kp(6'o31, 1'b0);
        8'h26: pos_o = kp(6'o32, 1'b0);
        8'h25: pos_o = kp(6'o33, 1'b0);
        8'h2E: pos_o = kp(6'o34, 1'b0);
        8'h45: pos_o = kp(6'o40, 1'b0);
        8'h46: pos_o = kp(6'o41, 1'b0);
        8'h3E: pos_o = kp(6'o42, 1'b0);
        8'h3D: pos_o = kp(6'o43, 1'b0);
        8'h36: pos_o = kp(6'o44, 1'b0);
        8'h4D: pos_o = kp(6'o50, 1'b0);
        8'h44: pos_o = kp(6'o51, 1'b0);
        8'h43: pos_o = kp(6'o52, 1'b0);
        8'h3C: pos_o = kp(6'o53, 1'b0);
        8'h35: pos_o = kp(6'o54, 1'b0);
        8'h5A: pos_o = kp(6'o60, 1'b0);
        8'h4B: pos_o = kp(6'o61, 1'b0);
        8'h42: pos_o = kp(6'o62, 1'b0);
        8'h3B: pos_o = kp(6'o63, 1'b0);
        8'h33: pos_o = kp(6'o64, 1'b0);
        8'h29: pos_o = kp(6'o70, 1'b0);
        8'h14: pos_o = kp(6'o71, 1'b0);
        8'h3A: pos_o = kp(6'o72, 1'b0);
        8'h31: pos_o = kp(6'o73, 1'b0);
        8'h32: pos_o = kp(6'o74, 1'b0);
        8'h66: pos_o = kp(6'o40, 1'b1);
        default: pos_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/ps2_keymatrix.sv
// PS/2 Set-2 make/break decoder driving an 8x5 Spectrum key matrix read via A15..A8.
// Optional Ctrl+Alt+Del reset request enabled by PS2_KEYMATRIX_RESET_KEY_EN.
module ps2_keymatrix
  import ps2_keymatrix_pkg::*;
#(
  parameter int unsigned ROWS    = ROWS_DEF,
  parameter int unsigned COLS    = COLS_DEF,
  parameter int unsigned E1_SKIP = 7,
  parameter int unsigned VCAPS_W = 3
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  ps2_keymatrix_if.slave   scan,
  input  logic [ROWS-1:0]  row_sel_n,
  output logic [COLS-1:0]  col_n,
  output logic             key_event,
  output logic             overflow_clr
`ifdef PS2_KEYMATRIX_RESET_KEY_EN
  ,
  output logic             cpu_reset_req
`endif
);

  localparam int unsigned SKIP_W = $clog2(E1_SKIP + 1);

  fsm_state_e                state_q, state_d;
  logic [SKIP_W-1:0]         skip_q, skip_d;
  logic [ROWS-1:0][COLS-1:0] matrix_q, matrix_d, pressed;
  logic [VCAPS_W-1:0]        vcaps_q, vcaps_d;
  logic [4:0]                held_q, held_d;
  logic [COLS-1:0]           col_q, col_or;
  logic                      ready_q, event_q, event_d, clr_q;
  logic                      accept, ext, brk, do_key, clr;
  logic [7:0]                code;
  logic [2:0]                cidx;
  key_pos_t                  pos;

  assign accept          = scan.scan_valid & ready_q;
  assign code            = scan.scan_data;
  assign scan.scan_ready = ready_q;
  assign col_n           = col_q;
  assign key_event       = event_q;
  assign overflow_clr    = clr_q;
  assign cidx            = combo_idx(pos.row, pos.col);

  ps2_keymap u_keymap (
    .ext_i  (ext),
    .code_i (code),
    .pos_o  (pos)
  );

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    ext     = 1'b0;
    brk     = 1'b0;
    do_key  = 1'b0;
    clr     = 1'b0;
    if (accept) begin
      unique case (state_q)
        StIdle: begin
          if (code == SC_EXT) begin
            state_d = StExt;
          end else if (code == SC_BRK) begin
            state_d = StBrk;
          end else if (code == SC_PAUSE) begin
            state_d = StSkip;
            skip_d  = SKIP_W'(E1_SKIP);
          end else if (code == 8'h00 || code == 8'hFF) begin
            clr = 1'b1;
          end else if (!(code inside {SC_BAT, SC_ECHO, SC_ACK, SC_RESEND})) begin
            do_key = 1'b1;
          end
        end
        StExt: begin
          ext = 1'b1;
          if (code == SC_BRK) begin
            state_d = StExtBrk;
          end else begin
            state_d = StIdle;
            // E0 12 / E0 59 are the fake shifts wrapped around extended keys.
            do_key  = !(code inside {8'h12, 8'h59});
          end
        end
        StBrk: begin
          state_d = StIdle;
          brk     = 1'b1;
          do_key  = 1'b1;
        end
        StExtBrk: begin
          state_d = StIdle;
          ext     = 1'b1;
          brk     = 1'b1;
          do_key  = 1'b1;
        end
        StSkip: begin
          skip_d = skip_q - 1'b1;
          if (skip_q <= SKIP_W'(1)) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    matrix_d = matrix_q;
    vcaps_d  = vcaps_q;
    held_d   = held_q;
    event_d  = 1'b0;
    if (clr) begin
      matrix_d = '0;
      vcaps_d  = '0;
      held_d   = '0;
    end else if (do_key && pos.valid) begin
      event_d                    = 1'b1;
      matrix_d[pos.row][pos.col] = ~brk;
      if (pos.combo) begin
        if (brk) begin
          if (vcaps_q != '0) vcaps_d = vcaps_q - 1'b1;
          held_d[cidx] = 1'b0;
        end else if (!held_q[cidx]) begin
          held_d[cidx] = 1'b1;
          if (vcaps_q != {VCAPS_W{1'b1}}) vcaps_d = vcaps_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    pressed       = matrix_q;
    pressed[0][0] = matrix_q[0][0] | (vcaps_q != '0);
    col_or        = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (!row_sel_n[r]) col_or = col_or | pressed[r];
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q  <= StIdle;
      skip_q   <= '0;
      matrix_q <= '0;
      vcaps_q  <= '0;
      held_q   <= '0;
      col_q    <= '1;
      ready_q  <= 1'b0;
      event_q  <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      skip_q   <= skip_d;
      matrix_q <= matrix_d;
      vcaps_q  <= vcaps_d;
      held_q   <= held_d;
      col_q    <= ~col_or;
      ready_q  <= 1'b1;
      event_q  <= event_d;
      clr_q    <= clr;
    end
  end

`ifdef PS2_KEYMATRIX_RESET_KEY_EN
  logic ctrl_q, alt_q, del_q, armed_q, rst_req_q;
  logic ctrl_d, alt_d, del_d, armed_d, rst_req_d, cad_hit;

  always_comb begin
    ctrl_d    = ctrl_q;
    alt_d     = alt_q;
    del_d     = del_q;
    armed_d   = armed_q;
    rst_req_d = 1'b0;
    cad_hit   = 1'b0;
    if (do_key) begin
      if (!ext && code == 8'h14) begin
        ctrl_d  = ~brk;
        cad_hit = 1'b1;
      end
      if (!ext && code == 8'h11) begin
        alt_d   = ~brk;
        cad_hit = 1'b1;
      end
      if (ext && code == 8'h71) begin
        del_d   = ~brk;
        cad_hit = 1'b1;
        if (brk) armed_d = 1'b1;
      end
      if (cad_hit && !brk && ctrl_d && alt_d && del_d && armed_q) begin
        rst_req_d = 1'b1;
        armed_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      ctrl_q    <= 1'b0;
      alt_q     <= 1'b0;
      del_q     <= 1'b0;
      armed_q   <= 1'b1;
      rst_req_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      alt_q     <= alt_d;
      del_q     <= del_d;
      armed_q   <= armed_d;
      rst_req_q <= rst_req_d;
    end
  end

  assign cpu_reset_req = rst_req_q;
`endif

endmodule

// File: tb/tb_ps2_keymatrix.sv
// Bench for ps2_keymatrix: directed steps then random scancodes against a byte-level model.
module tb_ps2_keymatrix;
  import ps2_keymatrix_pkg::*;

  logic       clk_clk = 1'b0;
  logic       reset_reset;
  logic [7:0] row_sel_n;
  logic [4:0] col_n;
  logic       key_event;
  logic       overflow_clr;
`ifdef PS2_KEYMATRIX_RESET_KEY_EN
  logic       cpu_reset_req;
`endif

  ps2_keymatrix_if bus ();

  ps2_keymatrix #(
    .ROWS    (8),
    .COLS    (5),
    .E1_SKIP (7),
    .VCAPS_W (3)
  ) dut (
    .clk_clk      (clk_clk),
    .reset_reset  (reset_reset),
    .scan         (bus),
    .row_sel_n    (row_sel_n),
    .col_n        (col_n),
    .key_event    (key_event),
    .overflow_clr (overflow_clr)
`ifdef PS2_KEYMATRIX_RESET_KEY_EN
    ,
    .cpu_reset_req(cpu_reset_req)
`endif
  );

  always #5 clk_clk = ~clk_clk;

  int vectors = 0;
  int miscompares = 0;

  // Keys listed row by row, column 0 first.
  logic [7:0] norm_codes [40] = '{
    8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A,  8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34,
    8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,  8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
    8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36,  8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35,
    8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33,  8'h29, 8'h14, 8'h3A, 8'h31, 8'h32};
  logic [7:0] combo_pool [5] = '{8'h66, 8'h6B, 8'h72, 8'h75, 8'h74};
  logic [7:0] misc_pool [6]  = '{8'h11, 8'h71, 8'h59, 8'hAA, 8'hFA, 8'hEE};

  int norm_map [logic [7:0]];
  int ext_map  [logic [7:0]];
  bit combo    [int];

  bit m_pressed [40];
  bit m_held    [int];
  int m_vcaps;
  bit m_ext, m_brk;
  int m_skip;
  bit m_ctrl, m_alt, m_del, m_armed;

  function automatic void model_reset();
    foreach (m_pressed[i]) m_pressed[i] = 1'b0;
    m_held.delete();
    m_vcaps = 0;
    m_ext   = 1'b0;
    m_brk   = 1'b0;
    m_skip  = 0;
    m_ctrl  = 1'b0;
    m_alt   = 1'b0;
    m_del   = 1'b0;
    m_armed = 1'b1;
  endfunction

  function automatic void model_key(input bit ext, input logic [7:0] code, input bit brk,
                                    output bit ev, output bit rq);
    int idx;
    int k;
    bit mapped;
    bit cad;
    ev     = 1'b0;
    rq     = 1'b0;
    idx    = 0;
    k      = int'(ext) * 256 + int'(code);
    mapped = 1'b0;
    if (ext && ext_map.exists(code)) begin
      mapped = 1'b1;
      idx    = ext_map[code];
    end else if (!ext && norm_map.exists(code)) begin
      mapped = 1'b1;
      idx    = norm_map[code];
    end
    if (mapped) begin
      ev             = 1'b1;
      m_pressed[idx] = !brk;
      if (combo.exists(k)) begin
        if (brk) begin
          if (m_vcaps > 0) m_vcaps--;
          m_held[k] = 1'b0;
        end else if (!(m_held.exists(k) && m_held[k])) begin
          m_held[k] = 1'b1;
          if (m_vcaps < 7) m_vcaps++;
        end
      end
    end
    cad = 1'b0;
`ifdef PS2_KEYMATRIX_RESET_KEY_EN
    if (!ext && code == 8'h14) begin m_ctrl = !brk; cad = 1'b1; end
    if (!ext && code == 8'h11) begin m_alt = !brk; cad = 1'b1; end
    if (ext && code == 8'h71) begin
      m_del = !brk;
      cad   = 1'b1;
      if (brk) m_armed = 1'b1;
    end
    if (cad && !brk && m_ctrl && m_alt && m_del && m_armed) begin
      rq      = 1'b1;
      m_armed = 1'b0;
    end
`endif
    if (cad) idx = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b, output bit ev, output bit clr,
                                     output bit rq);
    ev  = 1'b0;
    clr = 1'b0;
    rq  = 1'b0;
    if (m_skip > 0) begin
      m_skip--;
    end else if (m_brk) begin
      model_key(m_ext, b, 1'b1, ev, rq);
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (m_ext) begin
      m_ext = 1'b0;
      if (b != 8'h12 && b != 8'h59) model_key(1'b1, b, 1'b0, ev, rq);
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hE1) begin
      m_skip = 7;
    end else if (b == 8'h00 || b == 8'hFF) begin
      clr = 1'b1;
      foreach (m_pressed[i]) m_pressed[i] = 1'b0;
      m_held.delete();
      m_vcaps = 0;
    end else if (!(b inside {8'hAA, 8'hEE, 8'hFA, 8'hFE})) begin
      model_key(1'b0, b, 1'b0, ev, rq);
    end
  endfunction

  function automatic logic [4:0] model_col(input logic [7:0] rs);
    logic [4:0] r;
    r = 5'h1F;
    for (int row = 0; row < 8; row++) begin
      if (!rs[row]) begin
        for (int c = 0; c < 5; c++) begin
          if (m_pressed[row * 5 + c] || (row == 0 && c == 0 && m_vcaps > 0)) r[c] = 1'b0;
        end
      end
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    logic [4:0] pre_col;
    bit ev, clr, rq;
    pre_col = model_col(row_sel_n);
    model_byte(b, ev, clr, rq);
    bus.scan_data  = b;
    bus.scan_valid = 1'b1;
    @(posedge clk_clk);
    #1;
    bus.scan_valid = 1'b0;
    check($sformatf("key_event byte %02h", b), {31'd0, key_event}, {31'd0, ev});
    check($sformatf("overflow_clr byte %02h", b), {31'd0, overflow_clr}, {31'd0, clr});
    check($sformatf("col_n pre-update byte %02h", b), {27'd0, col_n}, {27'd0, pre_col});
`ifdef PS2_KEYMATRIX_RESET_KEY_EN
    check($sformatf("cpu_reset_req byte %02h", b), {31'd0, cpu_reset_req}, {31'd0, rq});
`endif
    if (rq) rq = 1'b0;
  endtask

  task automatic read(input logic [7:0] rs);
    row_sel_n = rs;
    @(posedge clk_clk);
    #1;
    check($sformatf("col_n row_sel %02h", rs), {27'd0, col_n}, {27'd0, model_col(rs)});
    check("key_event idle", {31'd0, key_event}, 32'd0);
    check("overflow_clr idle", {31'd0, overflow_clr}, 32'd0);
  endtask

  task automatic do_reset();
    bus.scan_valid = 1'b0;
    reset_reset    = 1'b1;
    repeat (2) @(posedge clk_clk);
    #1;
    check("reset scan_ready", {31'd0, bus.scan_ready}, 32'd0);
    check("reset col_n", {27'd0, col_n}, 32'h1F);
    check("reset key_event", {31'd0, key_event}, 32'd0);
    check("reset overflow_clr", {31'd0, overflow_clr}, 32'd0);
`ifdef PS2_KEYMATRIX_RESET_KEY_EN
    check("reset cpu_reset_req", {31'd0, cpu_reset_req}, 32'd0);
`endif
    reset_reset = 1'b0;
    model_reset();
    @(posedge clk_clk);
    #1;
    check("scan_ready after reset", {31'd0, bus.scan_ready}, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int sel;
    for (int i = 0; i < 40; i++) norm_map[norm_codes[i]] = i;
    norm_map[8'h59] = 0;
    norm_map[8'h66] = 20;
    ext_map[8'h6B]  = 19;
    ext_map[8'h72]  = 24;
    ext_map[8'h75]  = 23;
    ext_map[8'h74]  = 22;
    combo[8'h66]        = 1'b1;
    combo[256 + 8'h6B]  = 1'b1;
    combo[256 + 8'h72]  = 1'b1;
    combo[256 + 8'h75]  = 1'b1;
    combo[256 + 8'h74]  = 1'b1;

    bus.scan_data = 8'h00;
    row_sel_n     = 8'hFF;
    do_reset();

    read(8'hFE);
    row_sel_n = 8'hFD;
    send(8'h1C);
    read(8'hFD);
    send(8'hF0); send(8'h1C);
    read(8'hFD);

    send(8'h12);
    send(8'hE0); send(8'h6B);
    read(8'hF7);
    send(8'hE0); send(8'hF0); send(8'h6B);
    read(8'hFE);
    read(8'hF7);
    send(8'hF0); send(8'h12);
    read(8'hFE);

    send(8'h66); send(8'h66);
    read(8'hFE);
    send(8'hF0); send(8'h66);
    read(8'hEF);
    read(8'hFE);

    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'h1C);
    read(8'hFD);
    read(8'h7F);
    read(8'h00);

    send(8'h1A); send(8'h29);
    read(8'h00);
    send(8'hFF);
    read(8'h00);

    send(8'hE0); send(8'h12); send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h12);
    read(8'hEE);

`ifdef PS2_KEYMATRIX_RESET_KEY_EN
    send(8'h14); send(8'h11); send(8'hE0); send(8'h71);
    read(8'hFF);
    send(8'hE0); send(8'h71);
    send(8'h14);
    send(8'hE0); send(8'hF0); send(8'h71);
    send(8'hE0); send(8'h71);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h11);
    send(8'hE0); send(8'hF0); send(8'h71);
`endif

    send(8'hE1); send(8'h14);
    do_reset();
    send(8'h1C);
    read(8'hFD);
    send(8'hE0);
    do_reset();
    send(8'h6B);
    read(8'h00);

    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 50)      b = norm_codes[$urandom_range(0, 39)];
      else if (sel < 62) b = 8'hE0;
      else if (sel < 74) b = 8'hF0;
      else if (sel < 84) b = combo_pool[$urandom_range(0, 4)];
      else if (sel < 91) b = misc_pool[$urandom_range(0, 5)];
      else if (sel < 93) b = 8'hE1;
      else if (sel == 93) b = 8'hFF;
      else               b = 8'($urandom_range(0, 255));
      send(b);
      if ($urandom_range(0, 3) == 0) read(8'($urandom_range(0, 255)));
    end
    read(8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
